// File: rtl/game_start_ctrl.sv
// game_start_ctrl: lobby / countdown / run / game-over lifecycle controller
// for NUM_PLAYERS players, placed between the button front end and the game.
//
// Ports:
//   clk_i            system clock
//   rst_i            asynchronous, active-low reset
//   new_game_i       start / rematch request (level, rising edge used)
//   abort_i          synchronous abort back to the lobby
//   game_over_i      end-of-game report from the game logic (RUN only)
//   player_en_i      player enable switches
//   line_type_o      1 while the playfield is live (RUN)
//   active_players_o registered set of participating players
//   state_o          00 LOBBY, 01 COUNTDOWN, 10 RUN, 11 OVER
//   countdown_o      countdown steps remaining, 0 outside COUNTDOWN
//   start_pulse_o    one-cycle pulse on the cycle RUN is entered
//
// Optional build macro: AUTO_RESTART_EN
//   When defined, OVER re-enters COUNTDOWN by itself after STEPS*TICK_DIV
//   cycles without a start request (or drops to LOBBY if too few players).
//   When undefined, OVER waits for a start request or an abort.
//
// Parameter constraints: STEPS >= 1, TICK_DIV >= 1, CW must hold TICK_DIV-1.

module game_start_ctrl #(
    parameter int NUM_PLAYERS = 4,
    parameter int MIN_PLAYERS = 1,
    parameter int TICK_DIV    = 100000000,
    parameter int STEPS       = 3,
    parameter int CW          = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           new_game_i,
    input  logic                           abort_i,
    input  logic                           game_over_i,
    input  logic [NUM_PLAYERS-1:0]         player_en_i,
    output logic                           line_type_o,
    output logic [NUM_PLAYERS-1:0]         active_players_o,
    output logic [1:0]                     state_o,
    output logic [$clog2(STEPS+1)-1:0]     countdown_o,
    output logic                           start_pulse_o
);

    localparam int DW = $clog2(STEPS + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] STEPS_V  = DW'(STEPS);
    localparam logic [DW-1:0] CD_ONE   = DW'(1);

    typedef enum logic [1:0] {
        S_LOBBY     = 2'b00,
        S_COUNTDOWN = 2'b01,
        S_RUN       = 2'b10,
        S_OVER      = 2'b11
    } state_t;

    state_t          state;
    logic [CW-1:0]   div_q;
    logic            new_game_q;
    logic            rise;
    logic            enough;

`ifdef AUTO_RESTART_EN
    // Steps left in the OVER wait; kept apart from countdown_o so the
    // visible counter stays 0 while waiting for the automatic rematch.
    logic [DW-1:0]   wait_q;
`endif

    function automatic int popcnt(input logic [NUM_PLAYERS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    assign rise    = new_game_i & ~new_game_q;
    assign enough  = (popcnt(player_en_i) >= MIN_PLAYERS);
    assign state_o = state;

    // Single state machine; every output is a flop written here.
    // Priority per cycle: abort, game over, start edge, divider tick.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= S_LOBBY;
            line_type_o      <= 1'b0;
            countdown_o      <= '0;
            start_pulse_o    <= 1'b0;
            div_q            <= '0;
            new_game_q       <= 1'b0;
            // Lobby shows the switch setting even while held in reset.
            active_players_o <= player_en_i;
`ifdef AUTO_RESTART_EN
            wait_q           <= '0;
`endif
        end else begin
            new_game_q    <= new_game_i;
            start_pulse_o <= 1'b0;

            if (abort_i) begin
                state       <= S_LOBBY;
                line_type_o <= 1'b0;
                countdown_o <= '0;
                div_q       <= '0;
            end else begin
                unique case (state)
                    S_LOBBY: begin
                        active_players_o <= player_en_i;
                        if (rise && enough) begin
                            state       <= S_COUNTDOWN;
                            countdown_o <= STEPS_V;
                            div_q       <= '0;
                        end
                    end

                    S_COUNTDOWN: begin
                        active_players_o <= player_en_i;
                        if (!enough) begin
                            // Lost players mid-countdown: back to lobby.
                            state       <= S_LOBBY;
                            countdown_o <= '0;
                            div_q       <= '0;
                        end else if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            if (countdown_o == CD_ONE) begin
                                state         <= S_RUN;
                                line_type_o   <= 1'b1;
                                start_pulse_o <= 1'b1;
                                countdown_o   <= '0;
                            end else begin
                                countdown_o <= countdown_o - CD_ONE;
                            end
                        end else begin
                            div_q <= div_q + CW'(1);
                        end
                    end

                    S_RUN: begin
                        // Roster is frozen while the game is live.
                        if (game_over_i) begin
                            state       <= S_OVER;
                            line_type_o <= 1'b0;
                            div_q       <= '0;
`ifdef AUTO_RESTART_EN
                            wait_q      <= STEPS_V;
`endif
                        end
                    end

                    S_OVER: begin
                        active_players_o <= player_en_i;
                        if (rise) begin
                            div_q <= '0;
                            if (enough) begin
                                state       <= S_COUNTDOWN;
                                countdown_o <= STEPS_V;
                            end else begin
                                state <= S_LOBBY;
                            end
`ifdef AUTO_RESTART_EN
                        end else if (div_q == DIV_LAST) begin
                            div_q <= '0;
                            if (wait_q == CD_ONE) begin
                                if (enough) begin
                                    state       <= S_COUNTDOWN;
                                    countdown_o <= STEPS_V;
                                end else begin
                                    state <= S_LOBBY;
                                end
                            end else begin
                                wait_q <= wait_q - CD_ONE;
                            end
                        end else begin
                            div_q <= div_q + CW'(1);
`endif
                        end
                    end

                    default: begin
                        state <= S_LOBBY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_start_ctrl.sv
// tb_game_start_ctrl: scoreboard bench for game_start_ctrl with
// TICK_DIV=4, STEPS=3, MIN_PLAYERS=2, four players.

module tb_game_start_ctrl;

    localparam logic [1:0] L = 2'b00;
    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] O = 2'b11;

    logic       clk_i       = 1'b0;
    logic       rst_i       = 1'b0;
    logic       new_game_i  = 1'b0;
    logic       abort_i     = 1'b0;
    logic       game_over_i = 1'b0;
    logic [3:0] player_en_i = 4'b1010;
    logic       line_type_o;
    logic [3:0] active_players_o;
    logic [1:0] state_o;
    logic [1:0] countdown_o;
    logic       start_pulse_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       ln;
        logic [1:0] cd;
        logic       pl;
        logic [3:0] act;
    } exp_t;

    exp_t sb_q[$];

    game_start_ctrl #(
        .NUM_PLAYERS(4),
        .MIN_PLAYERS(2),
        .TICK_DIV   (4),
        .STEPS      (3),
        .CW         (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .new_game_i      (new_game_i),
        .abort_i         (abort_i),
        .game_over_i     (game_over_i),
        .player_en_i     (player_en_i),
        .line_type_o     (line_type_o),
        .active_players_o(active_players_o),
        .state_o         (state_o),
        .countdown_o     (countdown_o),
        .start_pulse_o   (start_pulse_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [1:0] st,
                        input logic ln, input logic [1:0] cd,
                        input logic pl, input logic [3:0] act);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ln  = ln;
        e.cd  = cd;
        e.pl  = pl;
        e.act = act;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
            chk({e.tag, ".line"}, 32'(line_type_o), 32'(e.ln));
            chk({e.tag, ".cd"}, 32'(countdown_o), 32'(e.cd));
            chk({e.tag, ".pulse"}, 32'(start_pulse_o), 32'(e.pl));
            chk({e.tag, ".act"}, 32'(active_players_o), 32'(e.act));
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        drain();
    endtask

    // Start edge from LOBBY/OVER, then follow the countdown into RUN.
    task automatic go_run(input string tag, input logic [3:0] pe);
        player_en_i = pe;
        new_game_i  = 1'b1;
        push({tag, ".enter"}, C, 1'b0, 2'd3, 1'b0, pe);
        step();
        new_game_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k < 12)
                push({tag, ".cd"}, C, 1'b0, 2'(3 - k / 4), 1'b0, pe);
            else
                push({tag, ".run"}, R, 1'b1, 2'd0, 1'b1, pe);
            step();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        push("rst", L, 1'b0, 2'd0, 1'b0, 4'b1010);
        drain();
        rst_i = 1'b1;
        push("lobby_idle", L, 1'b0, 2'd0, 1'b0, 4'b1010);
        step();
        player_en_i = 4'b0110;
        push("lobby_join", L, 1'b0, 2'd0, 1'b0, 4'b0110);
        step();

        game_over_i = 1'b1;
        push("go_lobby", L, 1'b0, 2'd0, 1'b0, 4'b0110);
        step();
        game_over_i = 1'b0;

        player_en_i = 4'b0001;
        new_game_i  = 1'b1;
        push("few_rise", L, 1'b0, 2'd0, 1'b0, 4'b0001);
        step();
        new_game_i = 1'b0;
        push("few_after", L, 1'b0, 2'd0, 1'b0, 4'b0001);
        step();

        // Start button held for 20 cycles: one countdown only.
        player_en_i = 4'b0011;
        new_game_i  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k < 12)
                push("cd_hold", C, 1'b0, 2'(3 - k / 4), 1'b0, 4'b0011);
            else
                push("run_hold", R, 1'b1, 2'd0, k == 12, 4'b0011);
            step();
        end

        new_game_i  = 1'b0;
        player_en_i = 4'b1111;
        push("run_frz", R, 1'b1, 2'd0, 1'b0, 4'b0011);
        step();
        game_over_i = 1'b1;
        push("over_in", O, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        game_over_i = 1'b0;
        push("over_upd", O, 1'b0, 2'd0, 1'b0, 4'b1111);
        step();
        new_game_i = 1'b1;
        push("rematch", C, 1'b0, 2'd3, 1'b0, 4'b1111);
        step();
        push("cd_ign", C, 1'b0, 2'd3, 1'b0, 4'b1111);
        step();
        player_en_i = 4'b0001;
        push("cd_drop", L, 1'b0, 2'd0, 1'b0, 4'b0001);
        step();

        new_game_i  = 1'b0;
        player_en_i = 4'b0011;
        push("lob_ret", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        new_game_i = 1'b1;
        push("ab_enter", C, 1'b0, 2'd3, 1'b0, 4'b0011);
        step();
        new_game_i = 1'b0;
        abort_i    = 1'b1;
        push("abort_cd", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        abort_i = 1'b0;
        push("ab_idle", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();

        go_run("run2", 4'b0011);
        abort_i     = 1'b1;
        game_over_i = 1'b1;
        push("ab_go", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        abort_i     = 1'b0;
        game_over_i = 1'b0;
        push("ab_go_idle", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();

        go_run("run3", 4'b0011);
        game_over_i = 1'b1;
        push("over3", O, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        game_over_i = 1'b0;
        player_en_i = 4'b0001;
        new_game_i  = 1'b1;
        push("over_few", L, 1'b0, 2'd0, 1'b0, 4'b0001);
        step();
        new_game_i  = 1'b0;
        player_en_i = 4'b0011;
        push("few_idle", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();

        go_run("run4", 4'b0011);
        game_over_i = 1'b1;
        push("over4", O, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        game_over_i = 1'b0;
`ifdef AUTO_RESTART_EN
        for (int k = 1; k <= 12; k++) begin
            if (k < 12)
                push("auto_wait", O, 1'b0, 2'd0, 1'b0, 4'b0011);
            else
                push("auto_cd", C, 1'b0, 2'd3, 1'b0, 4'b0011);
            step();
        end
`else
        for (int k = 1; k <= 100; k++) begin
            push("over_hold", O, 1'b0, 2'd0, 1'b0, 4'b0011);
            step();
        end
`endif
        abort_i = 1'b1;
        push("final_abort", L, 1'b0, 2'd0, 1'b0, 4'b0011);
        step();
        abort_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_start_ctrl.md
Name: game_start_ctrl

Overview:
Parametrised game start/lifecycle controller for N players. It holds a lobby in which players join or leave and an edge-triggered start request. A countdown of STEPS x TICK_DIV cycles follows with a visible step counter. The run phase enables the playfield via line_type_o, and a game-over state supports rematch. It sits between the button/switch front end and the game logic, and is the generalised successor of the single-shot start timer.

Parameters:
NUM_PLAYERS, 4, number of player-enable bits / active-player bits
MIN_PLAYERS, 1, minimum popcount of player_en_i required to start or continue the countdown
TICK_DIV, 100000000, clk_i cycles per countdown step (1 s at 100 MHz)
STEPS, 3, countdown steps before run
CW, 32, width of the internal tick divider; must hold TICK_DIV-1

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
new_game_i  in  1  start/rematch request, level; only its rising edge is used
abort_i  in  1  synchronous abort, level; returns to lobby
game_over_i  in  1  game logic reports end of game, level
player_en_i  in  NUM_PLAYERS  player enable switches
line_type_o  out  1  1 = playfield live (RUN), 0 otherwise
active_players_o  out  NUM_PLAYERS  registered set of participating players
state_o  out  2  00 LOBBY, 01 COUNTDOWN, 10 RUN, 11 OVER
countdown_o  out  $clog2(STEPS+1)  steps remaining; 0 outside COUNTDOWN
start_pulse_o  out  1  one-cycle pulse on the cycle RUN is entered

Behaviour:
- Reset (async, rst_i=0):
  - state LOBBY, line_type_o=0, countdown_o=0, start_pulse_o=0, divider=0, new_game edge register=0.
  - active_players_o=player_en_i, sampled asynchronously.
- Edge detect: rise = new_game_i & ~new_game_q. new_game_q is registered every cycle. A held-high button gives exactly one rise.
- Per-cycle priority: abort_i > game_over_i > rise > countdown tick.
- abort_i=1 in any state: next state LOBBY, line_type_o=0, countdown_o=0, divider=0.
- LOBBY:
  - active_players_o <= player_en_i every cycle.
  - On rise with popcount(player_en_i) >= MIN_PLAYERS: go to COUNTDOWN, countdown_o <= STEPS, divider <= 0.
  - On rise with too few players: ignored, stay in LOBBY.
- COUNTDOWN:
  - active_players_o <= player_en_i every cycle; players may still join or leave.
  - If popcount(player_en_i) < MIN_PLAYERS: go to LOBBY, countdown_o <= 0.
  - Else if divider == TICK_DIV-1: divider <= 0 and countdown_o decrements. If countdown_o was 1: go to RUN, line_type_o <= 1, start_pulse_o <= 1 for one cycle, countdown_o <= 0.
  - Else divider increments.
  - RUN is entered exactly STEPS*TICK_DIV cycles after the edge that entered COUNTDOWN.
  - A rise during COUNTDOWN is ignored; no restart.
- RUN:
  - active_players_o frozen.
  - game_over_i=1: go to OVER, line_type_o <= 0.
  - rise is ignored.
- OVER:
  - active_players_o <= player_en_i every cycle.
  - rise with enough players: go to COUNTDOWN (rematch), same entry actions as from LOBBY.
  - rise with too few players: go to LOBBY.
- game_over_i outside RUN has no effect.
- abort_i and game_over_i asserted together: abort wins (LOBBY).
- STEPS=0 is illegal; STEPS>=1 and TICK_DIV>=1 are required.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
AUTO_RESTART_EN
- Defined: in OVER, the divider counts, and after STEPS*TICK_DIV cycles with no rise the block enters COUNTDOWN automatically. This requires popcount >= MIN_PLAYERS; otherwise it goes to LOBBY. A rise in OVER still takes effect immediately. countdown_o stays 0 during the OVER wait.
- Undefined: OVER waits indefinitely for rise or abort_i. The divider is idle in OVER.

Test Plan:
- Reset with player_en_i=4'b1010, rst_i low for 3 cycles, then high: all outputs at reset values, active_players_o=1010, state_o=00. Toggle player_en_i to 0110 in LOBBY: active_players_o=0110 one cycle later.
- TICK_DIV=4, STEPS=3, player_en_i=0011, new_game_i held high 20 cycles: single COUNTDOWN entry. countdown_o reads 3,2,1, each for 4 cycles. state_o=10, line_type_o=1 and start_pulse_o=1 occur exactly 12 cycles after the edge. start_pulse_o is low the next cycle.
- MIN_PLAYERS=2, player_en_i=0001, rise: stays in LOBBY. Set 0011 and rise, then drop to 0001 mid-countdown: state_o=00, countdown_o=0 on the next cycle.
- In RUN, change player_en_i to 1111: active_players_o unchanged. Assert game_over_i: state_o=11, line_type_o=0. Then rise with 1111: COUNTDOWN, countdown_o=3, active_players_o=1111.
- abort_i and game_over_i high in the same cycle in RUN: state_o=00, line_type_o=0. Also assert abort_i mid-countdown: LOBBY, countdown_o=0.
- With AUTO_RESTART_EN: from OVER with 0011 and no rise, COUNTDOWN is entered after 12 cycles. Without the macro: still in OVER after 100 cycles.
